mul_ctrl: RTL

// - Control FSM for the repeated-addition multiplier: P = A * B by adding A into P, B times.
// - Drives the datapath strobes: A register load, P register clear/load, B down-counter load/decrement.
// - Consumes the counter zero flag `eqz` (dout == 0), computed combinationally in the datapath.
// - Provides a start/done handshake to the host, an abort input and a stuck-loop watchdog.

---
 rtl/mul_pkg.sv | 21 ++
 rtl/mul_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module : mul_pkg
// Desc   : Shared state encoding and widths for the repeated-addition
//          multiplier (controller and datapath).
// Rev    : 1.0  initial release
// ============================================================================
package mul_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ADD    = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mul_ctrl
// Desc   : Control FSM for the repeated-addition multiplier (P = A * B) with
//          start/done handshake, abort and stuck-loop watchdog.
// Rev    : 1.0  initial release
// ============================================================================
module mul_ctrl #(
  parameter int CNT_W    = mul_pkg::CNT_W,
  parameter int MAX_ITER = 2 ** CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic eqz,
  output logic lda,
  output logic clrp,
  output logic ldp,
  output logic ldb,
  output logic decb,
  output logic busy,
  output logic done,
  output logic err
);

  import mul_pkg::*;

  localparam int              c_iter_w   = $clog2(MAX_ITER + 1);
  localparam logic [c_iter_w-1:0] c_iter_max = c_iter_w'(MAX_ITER);

  state_t              r_state;
  state_t              w_next;
  logic [c_iter_w-1:0] r_iter;
  logic [c_iter_w-1:0] w_iter_inc;
  logic                w_accept;
  logic                w_wd_fire;
  logic                w_count;

  // Saturating so an over-long loop can never wrap back under the limit.
  assign w_iter_inc = (r_iter == c_iter_max) ? r_iter : r_iter + 1'b1;
  assign w_count    = (r_state == ADD) && !eqz && !abort;

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_wd_fire = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next   = LOAD_A;
          w_accept = 1'b1;
        end
      end
      LOAD_A: w_next = LOAD_B;
      LOAD_B: w_next = ADD;
      ADD: begin
        if (eqz) begin
          w_next = DONE;
        end else if (w_iter_inc == c_iter_max) begin
          w_next    = DONE;
          w_wd_fire = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          w_next   = LOAD_A;
          w_accept = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    // abort outranks start, eqz and the watchdog.
    if (abort) begin
      w_next    = IDLE;
      w_accept  = 1'b0;
      w_wd_fire = 1'b0;
    end
  end

  // Strobes decode from state; ADD is additionally qualified by eqz.
  assign lda  = !abort && (r_state == LOAD_A);
  assign ldb  = !abort && (r_state == LOAD_B);
  assign clrp = !abort && (r_state == LOAD_B);
  assign ldp  = w_count;
  assign decb = w_count;
  assign busy = (r_state == LOAD_A) || (r_state == LOAD_B) || (r_state == ADD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_iter  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      r_state <= w_next;
      done    <= (w_next == DONE);
      if (w_next == LOAD_A) begin
        r_iter <= '0;
      end else if (w_count) begin
        r_iter <= w_iter_inc;
      end
      if (w_accept) begin
        err <= 1'b0;
      end else if (w_wd_fire) begin
        err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
